// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES key schedule (FIPS-197 KeyExpansion).
// Produces one 32-bit schedule word per clock from an 8-word sliding window
// and fills a packed round-key array, round key 0 in the top slot.
`timescale 1ns/1ps
module aes_key_expand #(
   parameter int KEY_W    = 256,
   parameter int RK_SLOTS = 15
) (
   input  logic                     eph1,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [1:0]               key_size,
   input  logic [KEY_W-1:0]         true_key,
   output logic [RK_SLOTS:1][127:0] key_words,
   output logic                     busy,
   output logic                     ready
);

   typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;
   typedef enum logic [1:0] {KS_128, KS_192, KS_256} ksize_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Registered state
   state_t                   r_state;
   ksize_t                   r_ksize;
   logic [5:0]               r_i;        // index of the word written on the next edge
   logic [2:0]               r_phase;    // i mod Nk, tracked incrementally
   logic [7:0]               r_rcon;
   logic [7:0][31:0]         r_win;      // r_win[0] = w[i-1] ... r_win[7] = w[i-8]
   logic [RK_SLOTS:1][127:0] r_key_words;
   logic                     r_busy;
   logic                     r_ready;

   // Combinational helpers
   logic [255:0]     w_key;
   ksize_t           w_ksize_in;
   logic [7:0][31:0] w_win_init;
   logic [127:0]     w_slot2_init;
   logic [5:0]       w_i_init;
   logic [31:0]      w_back;
   logic [2:0]       w_phase_last;
   logic [5:0]       w_i_last;
   logic [31:0]      w_sub_in;
   logic [31:0]      w_sub;
   logic [31:0]      w_t;
   logic [31:0]      w_new;
   logic [7:0]       w_rcon_next;
   logic [3:0]       w_slot;
   logic [1:0]       w_lane;

   // Shorter keys are left-justified; their low bits never reach the schedule.
   assign w_key = true_key[KEY_W-1 -: 256];

   // Decode the requested key size into initial window, second slot and start index
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_ksize_in   = KS_256;
      w_win_init   = w_key;
      w_slot2_init = w_key[127:0];
      w_i_init     = 6'd8;
      case (key_size)
         2'b00: begin
            w_ksize_in   = KS_128;
            w_win_init   = {128'h0, w_key[255:128]};
            w_slot2_init = '0;
            w_i_init     = 6'd4;
         end
         2'b01: begin
            w_ksize_in   = KS_192;
            w_win_init   = {64'h0, w_key[255:64]};
            w_slot2_init = {w_key[127:64], 64'h0};
            w_i_init     = 6'd6;
         end
         default: ;
      endcase
   end

   // Per-size taps: w[i-Nk] position in the window, phase wrap and last word index
   always_comb begin
      w_back       = r_win[7];
      w_phase_last = 3'd7;
      w_i_last     = 6'd59;
      case (r_ksize)
         KS_128: begin
            w_back       = r_win[3];
            w_phase_last = 3'd3;
            w_i_last     = 6'd43;
         end
         KS_192: begin
            w_back       = r_win[5];
            w_phase_last = 3'd5;
            w_i_last     = 6'd51;
         end
         default: ;
      endcase
   end

   // RotWord only applies on the Nk boundary; the mid-block SubWord of 256-bit keys uses it unrotated.
   assign w_sub_in = (r_phase == 3'd0) ? {r_win[0][23:0], r_win[0][31:24]} : r_win[0];
   assign w_sub    = {SBOX[w_sub_in[31:24]], SBOX[w_sub_in[23:16]],
                      SBOX[w_sub_in[15:8]],  SBOX[w_sub_in[7:0]]};

   // Select the transformed previous word t for the current index
   always_comb begin
      w_t = r_win[0];
      if (r_phase == 3'd0)
         w_t = w_sub ^ {r_rcon, 24'h0};
      else if (r_ksize == KS_256 && r_phase == 3'd4)
         w_t = w_sub;
   end

   assign w_new       = w_back ^ w_t;
   assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
   assign w_slot      = 4'(RK_SLOTS) - r_i[5:2];
   assign w_lane      = 2'd3 - r_i[1:0];

   // Control FSM and schedule datapath, one word per edge while expanding
   always_ff @(posedge eph1 or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the round-key array is visible state, so it is cleared by reset like every other register.
         r_state     <= S_IDLE;
         r_ksize     <= KS_128;
         r_i         <= '0;
         r_phase     <= '0;
         r_rcon      <= 8'h01;
         r_win       <= '0;
         r_key_words <= '0;
         r_busy      <= 1'b0;
         r_ready     <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state                  <= S_EXPAND;
                  r_ksize                  <= w_ksize_in;
                  r_win                    <= w_win_init;
                  r_key_words              <= '0;
                  r_key_words[RK_SLOTS]    <= w_key[255:128];
                  r_key_words[RK_SLOTS-1]  <= w_slot2_init;
                  r_i                      <= w_i_init;
                  r_phase                  <= 3'd0;
                  r_rcon                   <= 8'h01;
                  r_busy                   <= 1'b1;
                  r_ready                  <= 1'b0;
               end
            end
            S_EXPAND: begin
               r_key_words[w_slot][{w_lane, 5'b0} +: 32] <= w_new;
               r_win   <= {r_win[6:0], w_new};
               r_phase <= (r_phase == w_phase_last) ? 3'd0 : r_phase + 3'd1;
               if (r_phase == 3'd0)
                  r_rcon <= w_rcon_next;
               if (r_i == w_i_last) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
               end else begin
                  r_i <= r_i + 6'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign key_words = r_key_words;
   assign busy      = r_busy;
   assign ready     = r_ready;

endmodule
